// File: rtl/dmem_ctrl.sv
// Data-memory controller for the MEM stage: byte-lane RAM behind a
// valid/ready request port, registered 1-cycle read, sized/signed loads.
module dmem_ctrl #(
  parameter int ADDR_W      = 12,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] resp_badaddr
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    HELD
  } state_t;

  state_t state_q, state_d;

  logic [31:0] mem [DEPTH];
  logic [31:0] ram_q;

  logic              accept;
  logic              bad_size;
  logic              bad_align;
  logic              bad_range;
  logic              req_err;
  logic [3:0]        be;
  logic [31:0]       wlane;
  logic [ADDR_W-3:0] idx;

  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] bad_q, bad_d;

  logic [31:0] hold_rdata_q, hold_rdata_d;
  logic        hold_err_q, hold_err_d;
  logic [31:0] hold_bad_q, hold_bad_d;

  logic [31:0] shifted;
  logic [31:0] fmt;

  assign resp_valid = (state_q != IDLE);
  assign req_ready  = !resp_valid | resp_ready;
  assign accept     = req_valid & req_ready;
  assign idx        = req_addr[ADDR_W-1:2];

  // Fault classification and store lane steering for the incoming request
  always_comb begin
    bad_size  = (req_size == 2'b11);
    bad_align = ((req_size == 2'b01) & req_addr[0]) |
                ((req_size == 2'b10) & (|req_addr[1:0]));
    bad_range = CHECK_RANGE && ((req_addr >> ADDR_W) != 32'd0);
    req_err   = bad_size | bad_align | bad_range;
    be        = 4'b0000;
    wlane     = req_wdata;
    unique case (req_size)
      2'b00: begin
        be    = 4'b0001 << req_addr[1:0];
        wlane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be    = req_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wlane = req_wdata;
      end
      default: begin
        be    = 4'b0000;
        wlane = req_wdata;
      end
    endcase
  end

  // RAM: byte-enable write and registered read, both at the accept edge
  always_ff @(posedge clk) begin
    if (resetn && accept) begin
      if (req_we && !req_err) begin
        for (int k = 0; k < 4; k++) begin
          if (be[k]) mem[idx][8*k +: 8] <= wlane[8*k +: 8];
        end
      end
      ram_q <= mem[idx];
    end
  end

  // Request attributes captured alongside the RAM read
  always_comb begin
    off_d  = off_q;
    size_d = size_q;
    sgn_d  = sgn_q;
    we_d   = we_q;
    err_d  = err_q;
    bad_d  = bad_q;
    if (accept) begin
      off_d  = req_addr[1:0];
      size_d = req_size;
      sgn_d  = req_signed;
      we_d   = req_we;
      err_d  = req_err;
      bad_d  = req_err ? req_addr : 32'd0;
    end
  end

  // Load alignment and extension of the registered read word
  always_comb begin
    shifted = ram_q >> {off_q, 3'b000};
    fmt     = 32'd0;
    if (!we_q && !err_q) begin
      unique case (size_q)
        2'b00:   fmt = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
        2'b01:   fmt = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
        default: fmt = ram_q;
      endcase
    end
  end

  // Response FSM: next state, hold-register capture and output muxing
  always_comb begin
    state_d      = state_q;
    hold_rdata_d = hold_rdata_q;
    hold_err_d   = hold_err_q;
    hold_bad_d   = hold_bad_q;
    resp_rdata   = 32'd0;
    resp_err     = 1'b0;
    resp_badaddr = 32'd0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = FIRST;
      end
      FIRST: begin
        resp_rdata   = fmt;
        resp_err     = err_q;
        resp_badaddr = bad_q;
        if (resp_ready) begin
          state_d = accept ? FIRST : IDLE;
        end else begin
          hold_rdata_d = fmt;
          hold_err_d   = err_q;
          hold_bad_d   = bad_q;
          state_d      = HELD;
        end
      end
      HELD: begin
        resp_rdata   = hold_rdata_q;
        resp_err     = hold_err_q;
        resp_badaddr = hold_bad_q;
        if (resp_ready) state_d = accept ? FIRST : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      off_q        <= 2'd0;
      size_q       <= 2'd0;
      sgn_q        <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      bad_q        <= 32'd0;
      hold_rdata_q <= 32'd0;
      hold_err_q   <= 1'b0;
      hold_bad_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      we_q         <= we_d;
      err_q        <= err_d;
      bad_q        <= bad_d;
      hold_rdata_q <= hold_rdata_d;
      hold_err_q   <= hold_err_d;
      hold_bad_q   <= hold_bad_d;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (ADDR_W=12, CHECK_RANGE=1).
module tb_dmem_ctrl;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] resp_badaddr;

  int checks   = 0;
  int failures = 0;

  dmem_ctrl #(.ADDR_W(12), .CHECK_RANGE(1'b1)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .resp_badaddr (resp_badaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  // One request from idle/consumed state; checks response one cycle later
  task automatic xact(input string tag, input logic we, input logic [1:0] sz,
                      input logic sg, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd,
                      input logic exp_err, input logic [31:0] exp_bad);
    @(negedge clk);
    drive(we, sz, sg, a, wd);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    chk({tag, "_bad"}, resp_badaddr, exp_bad);
  endtask

  initial begin
    resetn     = 1'b0;
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    #23;
    resetn = 1'b1;
    #1;
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_bad", resp_badaddr, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);

    xact("sw10", 1, 2'b10, 0, 32'h010, 32'h11223344, 32'h0, 0, 32'h0);
    xact("lw10", 0, 2'b10, 0, 32'h010, 32'h0, 32'h11223344, 0, 32'h0);
    xact("sb12", 1, 2'b00, 0, 32'h012, 32'hAB, 32'h0, 0, 32'h0);
    xact("lw10b", 0, 2'b10, 0, 32'h010, 32'h0, 32'h11AB3344, 0, 32'h0);
    xact("lb12", 0, 2'b00, 1, 32'h012, 32'h0, 32'hFFFFFFAB, 0, 32'h0);
    xact("lbu12", 0, 2'b00, 0, 32'h012, 32'h0, 32'h000000AB, 0, 32'h0);
    xact("lb13", 0, 2'b00, 1, 32'h013, 32'h0, 32'h00000011, 0, 32'h0);
    xact("lhu10", 0, 2'b01, 0, 32'h010, 32'h0, 32'h00003344, 0, 32'h0);

    xact("sw14", 1, 2'b10, 0, 32'h014, 32'hCAFE1234, 32'h0, 0, 32'h0);
    xact("sh16", 1, 2'b01, 0, 32'h016, 32'h8001, 32'h0, 0, 32'h0);
    xact("lh16", 0, 2'b01, 1, 32'h016, 32'h0, 32'hFFFF8001, 0, 32'h0);
    xact("lhu16", 0, 2'b01, 0, 32'h016, 32'h0, 32'h00008001, 0, 32'h0);
    xact("lw14", 0, 2'b10, 0, 32'h014, 32'h0, 32'h80011234, 0, 32'h0);

    xact("sw00", 1, 2'b10, 0, 32'h000, 32'hDEADBEEF, 32'h0, 0, 32'h0);
    xact("lw11", 0, 2'b10, 0, 32'h011, 32'h0, 32'h0, 1, 32'h00000011);
    xact("sw1000", 1, 2'b10, 0, 32'h1000, 32'h12345678, 32'h0, 1,
         32'h00001000);
    xact("lw00", 0, 2'b10, 0, 32'h000, 32'h0, 32'hDEADBEEF, 0, 32'h0);
    xact("sz11", 0, 2'b11, 0, 32'h020, 32'h0, 32'h0, 1, 32'h00000020);
    xact("sh13", 1, 2'b01, 0, 32'h013, 32'h5555, 32'h0, 1, 32'h00000013);
    xact("lw10c", 0, 2'b10, 0, 32'h010, 32'h0, 32'h11AB3344, 0, 32'h0);

    // Backpressure: A accepted, B waits while the consumer stalls
    @(negedge clk);
    resp_ready = 1'b0;
    drive(0, 2'b10, 0, 32'h010, 32'h0);
    @(posedge clk);
    #1;
    drive(0, 2'b10, 0, 32'h014, 32'h0);
    chk("bp_a_valid", {31'd0, resp_valid}, 32'd1);
    chk("bp_a_rdata", resp_rdata, 32'h11AB3344);
    chk("bp_ready0", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_hold_rdata", resp_rdata, 32'h11AB3344);
      chk("bp_hold_ready", {31'd0, req_ready}, 32'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    chk("bp_rel_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_rel_rdata", resp_rdata, 32'h11AB3344);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("bp_b_valid", {31'd0, resp_valid}, 32'd1);
    chk("bp_b_rdata", resp_rdata, 32'h80011234);
    chk("bp_b_err", {31'd0, resp_err}, 32'd0);
    @(posedge clk);
    #1;
    chk("bp_idle", {31'd0, resp_valid}, 32'd0);

    // Reset while a response is held
    @(negedge clk);
    resp_ready = 1'b0;
    drive(0, 2'b10, 0, 32'h014, 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("held_valid", {31'd0, resp_valid}, 32'd1);
    chk("held_rdata", resp_rdata, 32'h80011234);
    resetn = 1'b0;
    #1;
    chk("async_valid", {31'd0, resp_valid}, 32'd0);
    chk("async_rdata", resp_rdata, 32'd0);
    chk("async_bad", resp_badaddr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn     = 1'b1;
    resp_ready = 1'b1;
    xact("post_lw10", 0, 2'b10, 0, 32'h010, 32'h0, 32'h11AB3344, 0, 32'h0);
    xact("post_lw00", 0, 2'b10, 0, 32'h000, 32'h0, 32'hDEADBEEF, 0, 32'h0);

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
